sar_threshold_ctrl: RTL

Successive-approximation controller that drives the `threshold` side of the existing comparator block and reads back its decision. It steps a binary-search code onto a threshold DAC and samples the comparator output after a settle window. It produces a WIDTH-bit digital estimate of the analog `voltage_offset` input. The block sits between the digital control logic (start/done handshake) and the analog front end (track/hold, threshold DAC, comparator).

---
 rtl/sar_threshold_ctrl_pkg.sv | 21 ++
 rtl/sar_threshold_ctrl_tick_cnt.sv | 27 ++
 rtl/sar_threshold_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sar_threshold_ctrl_pkg.sv
// Shared types and defaults for the SAR threshold controller.
// Holds the FSM state encoding, default parameters and a midscale-code helper.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } sar_state_t;

    localparam int unsigned SAR_WIDTH      = 8;
    localparam int unsigned SAR_SAMPLE_CYC = 4;
    localparam int unsigned SAR_SETTLE     = 2;

    // First trial code of a conversion: only the MSB set (widths up to 16).
    function automatic logic [15:0] sar_midscale(input int unsigned width);
        return 16'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/sar_threshold_ctrl_tick_cnt.sv
// Loadable down-counter with a zero flag, shared by the sample and settle windows.
// Holds at zero until reloaded.
module sar_tick_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sar_threshold_ctrl.sv
// Successive-approximation controller: tracks, then binary-searches a DAC threshold
// against the comparator decision and reports a WIDTH-bit result with a done pulse.
module sar_threshold_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH      = SAR_WIDTH,
    parameter int unsigned SAMPLE_CYC = SAR_SAMPLE_CYC,
    parameter int unsigned SETTLE     = SAR_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IDX_W    = $clog2(WIDTH);
    localparam int unsigned TICK_MAX = (SAMPLE_CYC > SETTLE) ? SAMPLE_CYC : SETTLE;
    localparam int unsigned CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] MIDSCALE    = WIDTH'(sar_midscale(WIDTH));
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);

    sar_state_t       r_state;
    logic [WIDTH-1:0] r_dac_code;
    logic [WIDTH-1:0] r_result;
    logic [IDX_W-1:0] r_bit_idx;
    logic             r_sample;
    logic             r_busy;
    logic             r_done;

    logic             w_tick_zero;
    logic             w_tick_load;
    logic [CNT_W-1:0] w_tick_load_val;
    logic [WIDTH-1:0] w_decided;
    logic [WIDTH-1:0] w_next_code;

    sar_tick_cnt #(
        .CNT_W (CNT_W)
    ) u_tick_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tick_load),
        .i_load_val (w_tick_load_val),
        .o_zero     (w_tick_zero)
    );

    // Reload the window counter at the start of the track phase and each new bit trial.
    always_comb begin
        w_tick_load     = 1'b0;
        w_tick_load_val = SETTLE_LOAD;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_tick_load     = 1'b1;
                    w_tick_load_val = SAMPLE_LOAD;
                end
            end
            SAMPLE:  w_tick_load = w_tick_zero;
            CONVERT: w_tick_load = w_tick_zero && (r_bit_idx != '0);
            default: w_tick_load = 1'b0;
        endcase
    end

    // The DAC register doubles as the SAR register: resolve bit i, then seed bit i-1.
    always_comb begin
        w_decided            = r_dac_code;
        w_decided[r_bit_idx] = comp_in;
        w_next_code          = w_decided;
        if (r_bit_idx != '0) begin
            w_next_code[r_bit_idx - IDX_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dac_code <= '0;
            r_result   <= '0;
            r_bit_idx  <= '0;
            r_sample   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SAMPLE;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (w_tick_zero) begin
                        r_state    <= CONVERT;
                        r_sample   <= 1'b0;
                        r_dac_code <= MIDSCALE;
                        r_bit_idx  <= MSB_IDX;
                    end
                end
                CONVERT: begin
                    if (w_tick_zero) begin
                        r_dac_code <= w_next_code;
                        if (r_bit_idx != '0) begin
                            r_bit_idx <= r_bit_idx - IDX_W'(1);
                        end else begin
                            r_result <= w_next_code;
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_dac_code <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dac_code = r_dac_code;
    assign sample   = r_sample;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

endmodule
